// File: rtl/ofm_pkg.sv
// Shared types and constants for the OFM write scheduler.
package ofm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      AW,
      W,
      B,
      DONE
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam int         WORD_BYTES    = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the priority bit flips away from the
// requester that last completed a grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       last,
   output logic [1:0] gnt
);

   // Index of the requester that wins a tie; reset favours stream 0.
   logic prio_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_reg <= 1'b0;
      end else if (upd) begin
         prio_reg <= ~last;
      end
   end

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = prio_reg ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/ofm_wr_sched.sv
// Shares one AXI4 write master between two flattened-OFM streams, one burst
// per grant, counting acknowledged beats against a programmed total.
module ofm_wr_sched
   import ofm_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 512,
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_conv,
   input  logic [CNT_W-1:0]    total_beats,
   input  logic [DATA_W-1:0]   s0_tdata,
   input  logic                s0_valid,
   output logic                s0_ready,
   input  logic [ADDR_W-1:0]   s0_addr,
   input  logic [DATA_W-1:0]   s1_tdata,
   input  logic                s1_valid,
   output logic                s1_ready,
   input  logic [ADDR_W-1:0]   s1_addr,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [7:0]          m_awlen,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wlast,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output logic                done,
   output logic                err
);

   state_t             state_reg, state_next;
   logic               gsel_reg;
   logic [8:0]         blen_reg;
   logic [8:0]         bcnt_reg;
   logic [CNT_W-1:0]   remain_reg;
   logic               err_reg;
   logic [ADDR_W-1:0]  awaddr_reg;
   logic [7:0]         awlen_reg;

   logic [1:0]         gnt;
   logic               g_valid;
   logic               w_hs;
   logic [8:0]         blen_new;

   rr_arb2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  ({s1_valid, s0_valid}),
      .upd  ((state_reg == B) && m_bvalid),
      .last (gsel_reg),
      .gnt  (gnt)
   );

   // Burst is the smaller of the cap and what is still owed, so remain never underflows.
   assign blen_new = (remain_reg < CNT_W'(BURST_LEN)) ? remain_reg[8:0] : 9'(BURST_LEN);
   assign g_valid  = gsel_reg ? s1_valid : s0_valid;
   assign w_hs     = m_wvalid && m_wready;
   assign m_wlast  = (state_reg == W) && (bcnt_reg == blen_reg - 9'd1);
   assign m_wstrb  = '1;
   assign m_awaddr = awaddr_reg;
   assign m_awlen  = awlen_reg;
   assign done     = (state_reg == DONE);
   assign err      = err_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      m_awvalid  = 1'b0;
      m_wvalid   = 1'b0;
      m_bready   = 1'b0;
      s0_ready   = 1'b0;
      s1_ready   = 1'b0;
      m_wdata    = gsel_reg ? s1_tdata : s0_tdata;
      case (state_reg)
         IDLE, DONE: begin
            if (start_conv) begin
               state_next = (total_beats == '0) ? DONE : ARB;
            end
         end
         ARB: begin
            if (gnt != 2'b00) begin
               state_next = AW;
            end
         end
         AW: begin
            m_awvalid = 1'b1;
            if (m_awready) begin
               state_next = W;
            end
         end
         W: begin
            // Burst stays locked to the granted stream across source bubbles.
            m_wvalid = g_valid;
            s0_ready = !gsel_reg && m_wready;
            s1_ready = gsel_reg && m_wready;
            if (w_hs && m_wlast) begin
               state_next = B;
            end
         end
         B: begin
            m_bready = 1'b1;
            if (m_bvalid) begin
               state_next = (remain_reg == CNT_W'(blen_reg)) ? DONE : ARB;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gsel_reg   <= 1'b0;
         awaddr_reg <= '0;
         awlen_reg  <= '0;
         blen_reg   <= '0;
         bcnt_reg   <= '0;
         remain_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start_conv) begin
                  remain_reg <= total_beats;
                  err_reg    <= 1'b0;
               end
            end
            ARB: begin
               if (gnt != 2'b00) begin
                  gsel_reg   <= gnt[1];
                  awaddr_reg <= gnt[1] ? s1_addr : s0_addr;
                  blen_reg   <= blen_new;
                  awlen_reg  <= 8'(blen_new - 9'd1);
                  bcnt_reg   <= '0;
               end
            end
            W: begin
               if (w_hs) begin
                  bcnt_reg <= m_wlast ? 9'd0 : bcnt_reg + 9'd1;
               end
            end
            B: begin
               if (m_bvalid) begin
                  remain_reg <= remain_reg - CNT_W'(blen_reg);
                  if (m_bresp != AXI_RESP_OKAY) begin
                     err_reg <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ofm_wr_sched.sv
// Directed bench for ofm_wr_sched: modelled flatter sources and AXI slave,
// checks via immediate assertions in one linear stimulus sequence.
module tb_ofm_wr_sched;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 512;
   localparam int BL     = 4;
   localparam int CNT_W  = 32;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start_conv = 1'b0;
   logic [CNT_W-1:0]    total_beats = '0;
   logic [DATA_W-1:0]   s0_tdata = '0, s1_tdata = '0;
   logic                s0_valid = 1'b0, s1_valid = 1'b0;
   logic                s0_ready, s1_ready;
   logic [ADDR_W-1:0]   s0_addr = '0, s1_addr = '0;
   logic [ADDR_W-1:0]   m_awaddr;
   logic [7:0]          m_awlen;
   logic                m_awvalid;
   logic                m_awready = 1'b0;
   logic [DATA_W-1:0]   m_wdata;
   logic [DATA_W/8-1:0] m_wstrb;
   logic                m_wlast, m_wvalid;
   logic                m_wready = 1'b0;
   logic [1:0]          m_bresp = 2'b00;
   logic                m_bvalid = 1'b0;
   logic                m_bready, done, err;

   ofm_wr_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start_conv(start_conv), .total_beats(total_beats),
      .s0_tdata(s0_tdata), .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr),
      .s1_tdata(s1_tdata), .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
      .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Source, slave and recorder state
   int left0 = 0, left1 = 0, idx0 = 0, idx1 = 0, gap_at0 = -1, gap0 = 0;
   logic [63:0] base0 = 64'h1000, base1 = 64'h8000;
   int aw_stall_left = 0, err_burst = -1, bursts_done = 0;
   bit wtoggle = 0, b_pend = 0, aw_seen = 0, in_burst = 0;
   logic [63:0] aw_addr_q[$];
   logic [7:0]  aw_len_q[$];
   int          wlast_q[$];
   int beats = 0, pops0 = 0, pops1 = 0, bad_beats = 0, aw_unstable = 0, aw_stall_seen = 0, wgap = 0;
   logic [63:0] aw_a;
   logic [7:0]  aw_l;

   function automatic logic [DATA_W-1:0] word(input int id, input int idx);
      logic [31:0] w;
      w = (32'(id) << 24) | 32'(idx);
      return {16{w}};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive at the falling edge, then record what the next rising edge will accept.
   always @(negedge clk) begin
      bit p0, p1;
      m_awready = (aw_stall_left == 0);
      m_wready  = wtoggle ? ~m_wready : 1'b1;
      m_bvalid  = b_pend;
      m_bresp   = (bursts_done == err_burst) ? 2'b10 : 2'b00;
      if (gap0 > 0) begin
         s0_valid = 1'b0;
         gap0--;
      end else begin
         s0_valid = (left0 > 0);
      end
      s1_valid = (left1 > 0);
      s0_tdata = word(0, idx0);
      s1_tdata = word(1, idx1);
      s0_addr  = base0 + 64'(idx0) * 64;
      s1_addr  = base1 + 64'(idx1) * 64;
      #1;
      p0 = s0_valid && s0_ready;
      p1 = s1_valid && s1_ready;
      if (m_awvalid) begin
         if (!aw_seen) begin
            aw_seen = 1; aw_a = m_awaddr; aw_l = m_awlen;
         end else if (aw_a !== m_awaddr || aw_l !== m_awlen) begin
            aw_unstable++;
         end
         if (!m_awready) begin
            aw_stall_seen++;
            aw_stall_left--;
         end
      end
      if (in_burst && !m_wvalid) wgap++;
      if (m_awvalid && m_awready) begin
         aw_addr_q.push_back(m_awaddr);
         aw_len_q.push_back(m_awlen);
         aw_seen  = 0;
         in_burst = 1;
      end
      if (m_wvalid && m_wready) begin
         beats++;
         if (p0 == p1) bad_beats++;
         else if (p0 && m_wdata !== word(0, idx0)) bad_beats++;
         else if (p1 && m_wdata !== word(1, idx1)) bad_beats++;
         if (m_wlast) begin
            wlast_q.push_back(beats);
            in_burst = 0;
            b_pend   = 1;
         end
      end else if (p0 || p1) begin
         bad_beats++;
      end
      if (m_bvalid && m_bready) begin
         b_pend = 0;
         bursts_done++;
      end
      if (p0) begin
         idx0++; left0--; pops0++;
         if (pops0 == gap_at0) gap0 = 3;
      end
      if (p1) begin
         idx1++; left1--; pops1++;
      end
   end

   task automatic cfg_clear();
      left0 = 0; left1 = 0; idx0 = 0; idx1 = 0; gap_at0 = -1; gap0 = 0;
      aw_stall_left = 0; err_burst = -1; bursts_done = 0;
      wtoggle = 0; b_pend = 0; aw_seen = 0; in_burst = 0;
      aw_addr_q.delete(); aw_len_q.delete(); wlast_q.delete();
      beats = 0; pops0 = 0; pops1 = 0; bad_beats = 0;
      aw_unstable = 0; aw_stall_seen = 0; wgap = 0;
   endtask

   task automatic start(input int total);
      @(negedge clk); #3;
      total_beats = CNT_W'(total);
      start_conv  = 1'b1;
      @(negedge clk); #3;
      start_conv  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk); #2;
         if (done) break;
      end
      check(tag, 64'(done), 64'd1);
   endtask

   initial begin
      cfg_clear();
      // Reset state
      repeat (3) @(negedge clk);
      #3;
      check("rst_awvalid", 64'(m_awvalid), 0);
      check("rst_wvalid",  64'(m_wvalid), 0);
      check("rst_bready",  64'(m_bready), 0);
      check("rst_done",    64'(done), 0);
      check("rst_err",     64'(err), 0);
      check("rst_awaddr",  m_awaddr, 0);
      check("rst_awlen",   64'(m_awlen), 0);
      check("rst_wstrb",   64'(m_wstrb), 64'hFFFF_FFFF_FFFF_FFFF);
      rst = 1'b0;

      // Contention straight after reset: grants alternate 0,1,0,1
      left0 = 100; left1 = 100; base0 = 64'h1000; base1 = 64'h8000;
      start(16);
      wait_done("cont_done");
      check("cont_naw",   64'(aw_addr_q.size()), 4);
      check("cont_aw0",   aw_addr_q[0], 64'h1000);
      check("cont_aw1",   aw_addr_q[1], 64'h8000);
      check("cont_aw2",   aw_addr_q[2], 64'h1100);
      check("cont_aw3",   aw_addr_q[3], 64'h8100);
      check("cont_pops0", 64'(pops0), 8);
      check("cont_pops1", 64'(pops1), 8);
      check("cont_bad",   64'(bad_beats), 0);

      // Single stream, two full bursts
      cfg_clear();
      left0 = 8; base0 = 64'h1000;
      start(8);
      wait_done("single_done");
      check("single_naw",   64'(aw_addr_q.size()), 2);
      check("single_aw0",   aw_addr_q[0], 64'h1000);
      check("single_aw1",   aw_addr_q[1], 64'h1100);
      check("single_len0",  64'(aw_len_q[0]), 3);
      check("single_len1",  64'(aw_len_q[1]), 3);
      check("single_last0", 64'(wlast_q[0]), 4);
      check("single_last1", 64'(wlast_q[1]), 8);
      check("single_pops0", 64'(pops0), 8);
      check("single_pops1", 64'(pops1), 0);

      // Partial tail burst
      cfg_clear();
      left0 = 10; base0 = 64'h2000;
      start(6);
      wait_done("tail_done");
      repeat (4) @(negedge clk);
      #3;
      check("tail_len0",  64'(aw_len_q[0]), 3);
      check("tail_len1",  64'(aw_len_q[1]), 1);
      check("tail_aw1",   aw_addr_q[1], 64'h2100);
      check("tail_last1", 64'(wlast_q[1]), 6);
      check("tail_pops0", 64'(pops0), 6);

      // Backpressure: AW stall, toggling wready, 3-cycle source gap
      cfg_clear();
      left0 = 8; base0 = 64'h4000; aw_stall_left = 5; wtoggle = 1; gap_at0 = 2;
      start(8);
      wait_done("bp_done");
      check("bp_stall",    64'(aw_stall_seen), 5);
      check("bp_unstable", 64'(aw_unstable), 0);
      check("bp_aw0",      aw_addr_q[0], 64'h4000);
      check("bp_wgap",     64'(wgap), 3);
      check("bp_beats",    64'(beats), 8);
      check("bp_pops0",    64'(pops0), 8);
      check("bp_bad",      64'(bad_beats), 0);

      // Error response on first burst, then restart
      cfg_clear();
      left1 = 8; base1 = 64'h9000; err_burst = 0;
      start(8);
      wait_done("err_done");
      check("err_sticky", 64'(err), 1);
      check("err_aw0",    aw_addr_q[0], 64'h9000);
      check("err_pops1",  64'(pops1), 8);
      cfg_clear();
      left1 = 4; base1 = 64'h9000;
      start(4);
      check("restart_err",  64'(err), 0);
      check("restart_done", 64'(done), 0);
      wait_done("restart_fin");
      check("restart_err2", 64'(err), 0);

      // Asynchronous reset during W
      cfg_clear();
      left0 = 8; base0 = 64'h5000;
      start(8);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #2;
         if (beats >= 2) break;
      end
      check("arst_inw", 64'(m_wvalid), 1);
      rst = 1'b1;
      #1;
      check("arst_wvalid",  64'(m_wvalid), 0);
      check("arst_awvalid", 64'(m_awvalid), 0);
      check("arst_bready",  64'(m_bready), 0);
      check("arst_sready",  64'(s0_ready), 0);
      check("arst_done",    64'(done), 0);
      @(negedge clk); #3;
      cfg_clear();
      rst = 1'b0;
      left0 = 4; base0 = 64'h3000;
      start(4);
      wait_done("arst_after");
      check("arst_naw",   64'(aw_addr_q.size()), 1);
      check("arst_aw0",   aw_addr_q[0], 64'h3000);
      check("arst_pops0", 64'(pops0), 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ofm_wr_sched.md
Name: ofm_wr_sched

Overview:
- Shares one AXI4 write-master port between two flattened-OFM streams. Each stream is the 512-bit tdata/valid/ready output of one flatter instance, together with that instance's wmst_addr.
- Round-robin arbitration at burst granularity.
- Each grant issues one AW burst, then streams the W beats, then waits for B.
- Counts completed beats against a programmed total and raises done. Sits between the flatter pair and the shell's write master.

Parameters:
- ADDR_W, 64, AXI address width
- DATA_W, 512, data width; one beat is one flatter word
- BURST_LEN, 4, maximum beats per AW burst (1..256)
- CNT_W, 32, width of the beat counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_conv  in  1  one-cycle pulse: clears counters, done and err; arms the block
- total_beats  in  CNT_W  beats expected across both streams; sampled on start_conv
- s0_tdata  in  DATA_W  stream 0 data
- s0_valid  in  1  stream 0 valid
- s0_ready  out  1  stream 0 pop
- s0_addr  in  ADDR_W  byte address of stream 0's current head word
- s1_tdata, s1_valid, s1_ready, s1_addr  as stream 0, for stream 1
- m_awaddr  out  ADDR_W  burst address
- m_awlen  out  8  beats−1
- m_awvalid  out  1  address valid
- m_awready  in  1  address ready
- m_wdata  out  DATA_W  write data
- m_wstrb  out  DATA_W/8  all ones
- m_wlast  out  1  last beat of burst
- m_wvalid  out  1  data valid
- m_wready  in  1  data ready
- m_bresp  in  2  write response
- m_bvalid  in  1  response valid
- m_bready  out  1  response ready
- done  out  1  level; all total_beats acknowledged
- err  out  1  sticky; a non-OKAY bresp was received

Behaviour:
- Reset:
  - state=IDLE; all valid/ready outputs 0; m_awaddr=0, m_awlen=0.
  - done=0, err=0, rr pointer=0, counters=0.
  - Reset mid-burst abandons the transaction. The shell must also be reset.
- States: IDLE → ARB → AW → W → B → ARB or DONE.
- IDLE:
  - Waits for start_conv. Latches total_beats into remain.
  - total_beats=0 → DONE next cycle.
  - Otherwise → ARB.
- ARB:
  - Candidate streams are those with valid=1.
  - Both valid → grant the stream that is not the rr pointer's last grant. One valid → grant it. None → stay in ARB.
  - On grant, register:
    - gsel
    - m_awaddr = granted s*_addr
    - blen = min(BURST_LEN, remain)
    - m_awlen = blen−1
  - Then → AW. Grant takes 1 cycle; m_awvalid asserts the cycle after the grant.
- AW: m_awvalid=1 until m_awready, then → W. m_awaddr and m_awlen hold stable while valid.
- W:
  - m_wdata = granted tdata; m_wvalid = granted valid; granted s*_ready = m_wready.
  - The non-granted ready is 0.
  - Beat counter bcnt increments on each valid&ready handshake.
  - m_wlast = (bcnt==blen−1).
  - A source bubble deasserts m_wvalid; the burst stays locked to gsel.
  - Last handshake → B.
- B:
  - m_bready=1. On m_bvalid: remain −= blen; err |= (bresp!=0).
  - remain==0 → DONE. Otherwise → ARB, with the rr pointer set to gsel.
- DONE:
  - done=1 until the next start_conv, which re-arms the block and re-latches total_beats.
- start_conv outside IDLE/DONE is ignored, so an in-flight burst always completes.
- One outstanding transaction at a time; no AW/W overlap.
- Throughput bound: blen beats per (blen + 3 + slave latency) cycles.
- Arithmetic:
  - remain and bcnt are unsigned CNT_W and 9 bits respectively.
  - remain never underflows, because blen ≤ remain.
- Addresses pass through unmodified. The 64-byte alignment and 4 KB boundary are the flatter's and driver's responsibility.
- Both streams valid again in the following ARB → they alternate strictly: 0,1,0,1 after reset.

Decomposition:
- Shared package ofm_pkg:
  - state enum {IDLE, ARB, AW, W, B, DONE}
  - AXI_RESP_OKAY=2'b00
  - WORD_BYTES=64
- One natural sub-module: rr_arb2, a two-requester round-robin arbiter. Inputs: req[1:0], a last-grant update strobe, and the last grant. Output: a one-hot grant.
- Everything else is in the top FSM.

Test Plan:
- Single stream: s0 supplies 8 words at addr 0x1000, s1 idle, total_beats=8, BURST_LEN=4.
  - Response: two AW at 0x1000 and 0x1100 (the flatter advances the addr), awlen=3.
  - wlast on beats 4 and 8; done after the 2nd B.
- Contention: both streams always valid, total_beats=16, BURST_LEN=4.
  - Response: grants 0,1,0,1; each stream's ready pulses exactly 8 times; done=1.
- Partial tail: total_beats=6, BURST_LEN=4.
  - Response: awlen=3 then awlen=1; remain ends at 0; no extra beats popped.
- Backpressure:
  - m_awready held low 5 cycles → awaddr/awlen stable throughout.
  - m_wready toggled 1/0 → source pops only on handshakes; beat count stays exact.
  - Source valid gap of 3 cycles mid-burst → m_wvalid=0 for those 3 cycles, no lost or duplicated data.
- Error and restart: bresp=2'b10 on the 1st burst.
  - Response: err=1 sticky, the transfer still completes with done=1.
  - A following start_conv clears err and done.
- Reset: assert rst during the W state.
  - Response: all valids 0 and done=0 in the same cycle (asynchronous); state=IDLE; the next start_conv works normally.
